regfile_scoreboard: RTL and testbench

- Parametrised successor to the 2-read/1-write core register file.
- Generalises data width, depth and read-port count, and adds a per-register pending (scoreboard) bit so issue logic can stall on in-flight results.
- Adds a hardware zero register and a post-reset init sweep that clears every entry.
- Sits between decode/issue (reads, pending set) and writeback (data write, pending clear).

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_read_port.sv | 45 ++++
 rtl/regfile_scoreboard.sv | 109 ++++++++++
 tb/tb_regfile_scoreboard.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
package regfile_pkg;

  // Sweep-then-run controller states.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;

  // The hardware zero register is the highest index of the array.
  function automatic int zero_reg_idx(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: zero-register masking, stored value, and
// (with REGFILE_WB_BYPASS_EN defined) same-cycle writeback forwarding.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = zero_reg_idx(DEF_ADDR_W)
) (
  input  logic              running,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              stored_pending,
`ifdef REGFILE_WB_BYPASS_EN
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dest,
`endif
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_pending
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  // Select read result; everything reads as zero/not-pending during the sweep.
  always_comb begin
    rd_data    = '0;
    rd_pending = 1'b0;
    if (running && (rd_addr != ZERO_IDX)) begin
      rd_data    = stored_data;
      rd_pending = stored_pending;
`ifdef REGFILE_WB_BYPASS_EN
      // A result arriving this cycle retires the pending flag unless a new
      // producer claims the same register in the same cycle.
      if (wb_valid && (wb_dest == rd_addr)) begin
        rd_data    = wb_data;
        rd_pending = iss_valid && (iss_dest == rd_addr);
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised multi-read register file with per-entry pending bits,
// a hardwired zero register and a post-reset clearing sweep.
// Optional same-cycle writeback forwarding: define REGFILE_WB_BYPASS_EN.
//
// Handshake: there is no back-pressure. iss_valid and wb_valid are single
// cycle strobes sampled on posedge clock while ready is high; both are
// ignored while ready is low (init sweep).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = zero_reg_idx(ADDR_W)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  output logic                       ready,
  input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
  output logic [NUM_READ*DATA_W-1:0] rd_data,
  output logic [NUM_READ-1:0]        rd_pending,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_dest,
  input  logic                       wb_valid,
  input  logic [ADDR_W-1:0]          wb_dest,
  input  logic [DATA_W-1:0]          wb_data,
  output state_e                     dbg_state
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e              state;
  logic [ADDR_W-1:0]   sweep_idx;
  logic [DEPTH-1:0]    pending;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic wb_take;
  logic iss_take;

  assign wb_take   = wb_valid && (wb_dest != ZERO_IDX);
  assign iss_take  = iss_valid && (iss_dest != ZERO_IDX);
  assign dbg_state = state;

  // Controller: clearing sweep after reset, then pending-bit bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      sweep_idx <= '0;
      ready     <= 1'b0;
      pending   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          sweep_idx <= sweep_idx + 1'b1;
          if (sweep_idx == LAST_IDX) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          // Issue is applied after writeback so a new producer wins a tie.
          if (wb_take)  pending[wb_dest]  <= 1'b0;
          if (iss_take) pending[iss_dest] <= 1'b1;
        end
        default: begin
          state <= ST_INIT;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Data array: zeroed by the sweep, written by writeback once running.
  always_ff @(posedge clock) begin
    if (state == ST_INIT) begin
      mem[sweep_idx] <= '0;
    end else if (wb_take) begin
      mem[wb_dest] <= wb_data;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .running        (state == ST_RUN),
      .rd_addr        (addr),
      .stored_data    (mem[addr]),
      .stored_pending (pending[addr]),
`ifdef REGFILE_WB_BYPASS_EN
      .wb_valid       (wb_valid),
      .wb_dest        (wb_dest),
      .wb_data        (wb_data),
      .iss_valid      (iss_valid),
      .iss_dest       (iss_dest),
`endif
      .rd_data        (rd_data[i*DATA_W +: DATA_W]),
      .rd_pending     (rd_pending[i])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (default parameters, 2 read ports).
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int NR     = 2;
  localparam int DEPTH  = 256;

  logic                 clock;
  logic                 reset_n;
  logic                 ready;
  logic [NR*ADDR_W-1:0] rd_addr;
  logic [NR*DATA_W-1:0] rd_data;
  logic [NR-1:0]        rd_pending;
  logic                 iss_valid;
  logic [ADDR_W-1:0]    iss_dest;
  logic                 wb_valid;
  logic [ADDR_W-1:0]    wb_dest;
  logic [DATA_W-1:0]    wb_data;
  state_e               dbg_state;

  int checks   = 0;
  int failures = 0;

  // Expected {pending, data} per read, pushed when the read is driven.
  logic [DATA_W:0] exp_q[$];

  regfile_scoreboard u_dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ready      (ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .iss_valid  (iss_valid),
    .iss_dest   (iss_dest),
    .wb_valid   (wb_valid),
    .wb_dest    (wb_dest),
    .wb_data    (wb_data),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock/reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_read(input int p, input logic [ADDR_W-1:0] a);
    rd_addr[p*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic drive_wb(input logic v, input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] x);
    wb_valid = v;
    wb_dest  = d;
    wb_data  = x;
  endtask

  task automatic drive_iss(input logic v, input logic [ADDR_W-1:0] d);
    iss_valid = v;
    iss_dest  = d;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_read(input logic pend, input logic [DATA_W-1:0] d);
    exp_q.push_back({pend, d});
  endtask

  task automatic compare_read(input int p, input string tag);
    logic [DATA_W:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      #1;
      check(tag, 64'({rd_pending[p], rd_data[p*DATA_W +: DATA_W]}), 64'(e));
    end
  endtask

  // Count posedges until ready rises; optionally reset mid-sweep at abort_at.
  task automatic wait_ready(output int n, input int abort_at);
    n = 0;
    while (!ready && n < 1000) begin
      step();
      n++;
      if (n == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("midsweep_rst_state", 64'(dbg_state), 64'(ST_INIT));
        check("midsweep_rst_ready", 64'(ready), 64'd0);
        step();
        step();
        reset_n = 1'b1;
        n = 0;
        abort_at = -1;
      end
      if (n == 128) begin
        set_read(0, 8'd250);
        expect_read(1'b0, '0);
        compare_read(0, "init_read_zero");
      end
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      set_read(0, 8'(i));
      set_read(1, 8'(DEPTH - 1 - i));
      expect_read(1'b0, '0);
      expect_read(1'b0, '0);
      compare_read(0, {tag, "_p0"});
      compare_read(1, {tag, "_p1"});
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int n;
    logic [DATA_W-1:0] rnd [4];

    reset_n = 1'b0;
    rd_addr = '0;
    drive_wb(1'b0, '0, '0);
    drive_iss(1'b0, '0);
    repeat (3) step();

    check("rst_ready", 64'(ready), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_INIT));
    check("rst_pending", 64'(rd_pending), 64'd0);

    // Traffic held during the whole sweep must be ignored.
    drive_wb(1'b1, 8'd3, 32'hABCD_0123);
    drive_iss(1'b1, 8'd3);
    reset_n = 1'b1;
    wait_ready(n, -1);
    check("sweep_cycles", 64'(n), 64'd256);
    check("run_state", 64'(dbg_state), 64'(ST_RUN));
    drive_wb(1'b0, '0, '0);
    drive_iss(1'b0, '0);
    read_all_zero("post_sweep");

    // Writeback to 5: same-cycle and next-cycle visibility.
    set_read(0, 8'd5);
    drive_wb(1'b1, 8'd5, 32'hDEAD_BEEF);
`ifdef REGFILE_WB_BYPASS_EN
    expect_read(1'b0, 32'hDEAD_BEEF);
`else
    expect_read(1'b0, 32'h0);
`endif
    compare_read(0, "wb5_same");
    step();
    drive_wb(1'b0, '0, '0);
    expect_read(1'b0, 32'hDEAD_BEEF);
    compare_read(0, "wb5_next");

    // Issue to 7, then its writeback three cycles later.
    set_read(0, 8'd7);
    drive_iss(1'b1, 8'd7);
    expect_read(1'b0, 32'h0);
    compare_read(0, "iss7_same");
    step();
    drive_iss(1'b0, '0);
    expect_read(1'b1, 32'h0);
    compare_read(0, "iss7_t1");
    step();
    step();
    drive_wb(1'b1, 8'd7, 32'h12);
`ifdef REGFILE_WB_BYPASS_EN
    expect_read(1'b0, 32'h12);
`else
    expect_read(1'b1, 32'h0);
`endif
    compare_read(0, "wb7_t3");
    step();
    drive_wb(1'b0, '0, '0);
    expect_read(1'b0, 32'h12);
    compare_read(0, "wb7_t4");

    // Issue and writeback to 9 together: the new producer keeps it pending.
    set_read(1, 8'd9);
    drive_iss(1'b1, 8'd9);
    drive_wb(1'b1, 8'd9, 32'h55);
`ifdef REGFILE_WB_BYPASS_EN
    expect_read(1'b1, 32'h55);
`else
    expect_read(1'b0, 32'h0);
`endif
    compare_read(1, "tie9_same");
    step();
    drive_iss(1'b0, '0);
    drive_wb(1'b0, '0, '0);
    expect_read(1'b1, 32'h55);
    compare_read(1, "tie9_next");

    // Zero register ignores writes and issues.
    set_read(0, 8'd255);
    set_read(1, 8'd254);
    drive_wb(1'b1, 8'd255, 32'hFFFF_FFFF);
    drive_iss(1'b1, 8'd255);
    expect_read(1'b0, 32'h0);
    compare_read(0, "zero_same");
    step();
    drive_wb(1'b0, '0, '0);
    drive_iss(1'b0, '0);
    expect_read(1'b0, 32'h0);
    expect_read(1'b0, 32'h0);
    compare_read(0, "zero_next");
    compare_read(1, "zero_neighbour");

    // Random data into entries 10..13, read back on port 1.
    for (int i = 0; i < 4; i++) begin
      rnd[i] = $urandom_range(32'h7FFF_FFFF, 1);
      drive_wb(1'b1, 8'(10 + i), rnd[i]);
      step();
    end
    drive_wb(1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      set_read(1, 8'(10 + i));
      expect_read(1'b0, rnd[i]);
      compare_read(1, "rand_rd");
    end

    // Leave 20 pending, then reset asynchronously in RUN.
    drive_iss(1'b1, 8'd20);
    step();
    drive_iss(1'b0, '0);
    set_read(0, 8'd20);
    expect_read(1'b1, 32'h0);
    compare_read(0, "pend20");
    reset_n = 1'b0;
    #1;
    check("async_ready_drop", 64'(ready), 64'd0);
    check("async_pend_clear", 64'(u_dut.pending[20]), 64'd0);
    step();
    step();
    reset_n = 1'b1;

    // Second reset lands at sweep index 100; the sweep must restart in full.
    wait_ready(n, 100);
    check("resweep_cycles", 64'(n), 64'd256);
    read_all_zero("post_resweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
